// File: rtl/sub_serial.sv
// Digit-serial subtractor: d = a - b, DIGIT bits per RUN cycle through a
// registered borrow chain, with valid/ready handshakes on operands and result.
module sub_serial #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             borrow,
    output logic             overflow,
    output logic             zero
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg, b_reg, d_reg;
    logic [CW-1:0]    cnt_reg;
    logic             bor_reg;
    logic             a_msb_reg, b_msb_reg;
    logic             borrow_reg, overflow_reg, zero_reg;

    logic [DIGIT:0]   chain;
    logic [DIGIT-1:0] dig;
    logic [WIDTH-1:0] d_next;

    assign chain[0] = bor_reg;

    // Borrow ripples through the DIGIT lowest unprocessed bits each cycle.
    generate
        for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
            logic ai, bi;
            assign ai           = a_reg[gi];
            assign bi           = b_reg[gi];
            assign dig[gi]      = ai ^ bi ^ chain[gi];
            assign chain[gi+1]  = (~ai & bi) | (chain[gi] & ~(ai ^ bi));
        end
        if (WIDTH > DIGIT) begin : g_shift
            assign d_next = {dig, d_reg[WIDTH-1:DIGIT]};
        end else begin : g_whole
            assign d_next = dig;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            a_reg        <= '0;
            b_reg        <= '0;
            d_reg        <= '0;
            cnt_reg      <= '0;
            bor_reg      <= 1'b0;
            a_msb_reg    <= 1'b0;
            b_msb_reg    <= 1'b0;
            borrow_reg   <= 1'b0;
            overflow_reg <= 1'b0;
            zero_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        a_msb_reg <= a[WIDTH-1];
                        b_msb_reg <= b[WIDTH-1];
                        bor_reg   <= 1'b0;
                        cnt_reg   <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    a_reg   <= a_reg >> DIGIT;
                    b_reg   <= b_reg >> DIGIT;
                    d_reg   <= d_next;
                    bor_reg <= chain[DIGIT];
                    cnt_reg <= cnt_reg + 1'b1;
                    // Flags are taken from the final digit's combinational result.
                    if (cnt_reg == LAST) begin
                        state_reg    <= DONE;
                        borrow_reg   <= chain[DIGIT];
                        overflow_reg <= (a_msb_reg != b_msb_reg) &&
                                        (d_next[WIDTH-1] != a_msb_reg);
                        zero_reg     <= (d_next == '0);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign d         = d_reg;
    assign borrow    = borrow_reg;
    assign overflow  = overflow_reg;
    assign zero      = zero_reg;
endmodule

// File: tb/tb_sub_serial.sv
// Directed and random checks of sub_serial: a bit-serial build and a
// 4-bit-digit build share clock and reset.
module tb_sub_serial;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid1 = 1'b0, out_ready1 = 1'b0;
    logic [31:0] a1 = '0, b1 = '0;
    logic        in_ready1, out_valid1, borrow1, overflow1, zero1;
    logic [31:0] d1;
    logic        in_valid4 = 1'b0, out_ready4 = 1'b0;
    logic [31:0] a4 = '0, b4 = '0;
    logic        in_ready4, out_valid4, borrow4, overflow4, zero4;
    logic [31:0] d4;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sub_serial #(.WIDTH(32), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
        .d(d1), .borrow(borrow1), .overflow(overflow1), .zero(zero1)
    );

    sub_serial #(.WIDTH(32), .DIGIT(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
        .d(d4), .borrow(borrow4), .overflow(overflow4), .zero(zero4)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic        bo;
        logic        ov;
        logic        z;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // One operation on the DIGIT=1 instance; returns result and accept-to-valid latency.
    task automatic run1(input logic [31:0] aa, input logic [31:0] bb,
                        output logic [31:0] dd, output logic bo, output logic ov,
                        output logic z, output int lat);
        int w = 0;
        @(negedge clk);
        while (!in_ready1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_before_accept", 32'(in_ready1), 32'd1);
        a1 = aa; b1 = bb; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0; a1 = $urandom; b1 = $urandom;
        lat = 0;
        while (!out_valid1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        dd = d1; bo = borrow1; ov = overflow1; z = zero1;
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        check("in_ready_after_consume", 32'(in_ready1), 32'd1);
        check("out_valid_after_consume", 32'(out_valid1), 32'd0);
    endtask

    initial begin
        logic [31:0] dd;
        logic        bo, ov, z;
        int          lat;
        int          last_acc;

        vecs[0] = '{32'd5,          32'd3,          32'd2,          1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'd0,          32'd1,          32'hFFFF_FFFF,  1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'h1234_5678,  32'h1234_5678,  32'd0,          1'b0, 1'b0, 1'b1};
        vecs[4] = '{32'h7FFF_FFFF,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1, 1'b1, 1'b0};
        vecs[5] = '{32'd100,        32'd58,         32'd42,         1'b0, 1'b0, 1'b0};
        vecs[6] = '{32'hFFFF_FFFF,  32'h7FFF_FFFF,  32'h8000_0000,  1'b0, 1'b0, 1'b0};
        vecs[7] = '{32'h8000_0000,  32'h7FFF_FFFF,  32'd1,          1'b0, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_in_ready", 32'(in_ready1), 32'd1);
        check("reset_out_valid", 32'(out_valid1), 32'd0);
        check("reset_d", d1, 32'd0);
        check("reset_borrow", 32'(borrow1), 32'd0);
        check("reset_overflow", 32'(overflow1), 32'd0);
        check("reset_zero", 32'(zero1), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run1(vecs[i].a, vecs[i].b, dd, bo, ov, z, lat);
            $display("op a=%h b=%h -> d=%h borrow=%0b overflow=%0b zero=%0b latency=%0d",
                     vecs[i].a, vecs[i].b, dd, bo, ov, z, lat);
            check("latency", 32'(lat), 32'd32);
            check("d", dd, vecs[i].d);
            check("borrow", 32'(bo), 32'(vecs[i].bo));
            check("overflow", 32'(ov), 32'(vecs[i].ov));
            check("zero", 32'(z), 32'(vecs[i].z));
        end

        // Stall in DONE while operand-side inputs churn.
        @(negedge clk);
        a1 = 32'h0000_1000; b1 = 32'd1; in_valid1 = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (!out_valid1 && lat < 100) begin
            a1 = $urandom; b1 = $urandom; in_valid1 = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        check("hold_latency", 32'(lat), 32'd32);
        for (int k = 0; k < 10; k++) begin
            a1 = $urandom; b1 = $urandom; in_valid1 = 1'($urandom);
            @(posedge clk); #1;
            check("hold_d", d1, 32'h0000_0FFF);
            check("hold_flags", {29'd0, borrow1, overflow1, zero1}, 32'd0);
            check("hold_in_ready", 32'(in_ready1), 32'd0);
            check("hold_out_valid", 32'(out_valid1), 32'd1);
        end
        $display("op a=00001000 b=00000001 held 10 cycles -> d=%h", d1);
        in_valid1 = 1'b0; out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;

        // Reset in the middle of RUN discards the operation.
        @(negedge clk);
        a1 = 32'd5; b1 = 32'd3; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrun_rst_in_ready", 32'(in_ready1), 32'd1);
        check("midrun_rst_out_valid", 32'(out_valid1), 32'd0);
        check("midrun_rst_d", d1, 32'd0);
        run1(32'd100, 32'd58, dd, bo, ov, z, lat);
        $display("op after reset a=100 b=58 -> d=%0d latency=%0d", dd, lat);
        check("post_rst_latency", 32'(lat), 32'd32);
        check("post_rst_d", dd, 32'd42);

        // DIGIT=4 build: back-to-back random operations against a reference.
        out_ready4 = 1'b1;
        last_acc = 0;
        for (int i = 0; i < 1000; i++) begin
            logic [31:0]        ra, rb, exp_d;
            logic signed [32:0] sd;
            int                 w;
            ra = $urandom; rb = $urandom;
            if (i % 50 == 0) rb = ra;
            exp_d = ra - rb;
            sd = $signed({ra[31], ra}) - $signed({rb[31], rb});
            w = 0;
            @(negedge clk);
            while (!in_ready4 && w < 100) begin
                @(negedge clk);
                w++;
            end
            a4 = ra; b4 = rb; in_valid4 = 1'b1;
            @(posedge clk); #1;
            in_valid4 = 1'b0; a4 = $urandom; b4 = $urandom;
            if (i > 0) check("d4_spacing", 32'(cyc - last_acc >= 10), 32'd1);
            last_acc = cyc;
            lat = 0;
            while (!out_valid4 && lat < 100) begin
                @(posedge clk); #1;
                lat++;
            end
            $display("op4 a=%h b=%h -> d=%h borrow=%0b overflow=%0b zero=%0b latency=%0d",
                     ra, rb, d4, borrow4, overflow4, zero4, lat);
            check("d4_latency", 32'(lat), 32'd8);
            check("d4_d", d4, exp_d);
            check("d4_borrow", 32'(borrow4), 32'(ra < rb));
            check("d4_overflow", 32'(overflow4), 32'(sd[32] != sd[31]));
            check("d4_zero", 32'(zero4), 32'(exp_d == 32'd0));
            @(posedge clk); #1;
        end
        out_ready4 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
